// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the multiply/divide unit.
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int          MDU_ITER    = 32;
  localparam logic [31:0] MDU_DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_sign_fix.sv
// Signed-operand magnitude extraction and result sign restoration for MULT/DIV.
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic [WIDTH-1:0]   mag_a,
  output logic [WIDTH-1:0]   mag_b,
  output logic               sign_a,
  output logic               sign_b,
  input  logic               is_div,
  input  logic               neg_q,
  input  logic               neg_r,
  input  logic [2*WIDTH-1:0] raw,
  output logic [WIDTH-1:0]   res_hi,
  output logic [WIDTH-1:0]   res_lo
);

  logic               is_signed;
  logic [2*WIDTH-1:0] prod_fix;

  // Operand side uses the live request; result side uses flags latched at accept.
  always_comb begin
    is_signed = (op == MDU_MULT) || (op == MDU_DIV);
    sign_a    = is_signed && src_a[WIDTH-1];
    sign_b    = is_signed && src_b[WIDTH-1];
    mag_a     = sign_a ? -src_a : src_a;
    mag_b     = sign_b ? -src_b : src_b;
    prod_fix  = neg_q ? -raw : raw;
    if (is_div) begin
      res_hi = neg_r ? -raw[2*WIDTH-1:WIDTH] : raw[2*WIDTH-1:WIDTH];
      res_lo = neg_q ? -raw[WIDTH-1:0] : raw[WIDTH-1:0];
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing architectural HI/LO, one iteration per cycle.
// Optional build macro MDU_EARLY_TERM_EN: multiplies stop once the remaining multiplier bits are zero.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = MDU_ITER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(ITER) + 1;

  logic [1:0]         state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [1:0]         op_r;
  logic               neg_q_r, neg_r_r, div0_r;
  logic [2*WIDTH-1:0] acc_r, mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic               busy_r, done_r;
  logic [WIDTH-1:0]   hi_r, lo_r;

  logic               accept_s, last_s, early_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s, res_hi_s, res_lo_s;
  logic               sign_a_s, sign_b_s;
  logic [WIDTH:0]     up_s, diff_s;
  logic [2*WIDTH-1:0] acc_nxt_s;

  assign accept_s = start && (state_r != ST_RUN);
  assign busy     = busy_r;
  assign done     = done_r;
  assign hi       = hi_r;
  assign lo       = lo_r;

  mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .mag_a  (mag_a_s),
    .mag_b  (mag_b_s),
    .sign_a (sign_a_s),
    .sign_b (sign_b_s),
    .is_div (op_r[1]),
    .neg_q  (neg_q_r),
    .neg_r  (neg_r_r),
    .raw    (acc_nxt_s),
    .res_hi (res_hi_s),
    .res_lo (res_lo_s)
  );

  // Divide keeps {remainder, quotient} in acc_r with the divisor in mcand_r's low half.
  always_comb begin
    up_s   = acc_r[2*WIDTH-1:WIDTH-1];
    diff_s = up_s - {1'b0, mcand_r[WIDTH-1:0]};
    if (op_r[1]) begin
      if (up_s >= {1'b0, mcand_r[WIDTH-1:0]}) begin
        acc_nxt_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt_s = {up_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end
    end else if (mplier_r[0]) begin
      acc_nxt_s = acc_r + mcand_r;
    end else begin
      acc_nxt_s = acc_r;
    end
  end

`ifdef MDU_EARLY_TERM_EN
  assign early_s = !op_r[1] && (mplier_r[WIDTH-1:1] == {(WIDTH-1){1'b0}});
`else
  assign early_s = 1'b0;
`endif
  assign last_s = (cnt_r == CNT_W'(ITER - 1)) || early_s;

  // Control FSM, datapath iteration and HI/LO register updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      op_r     <= 2'b00;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      div0_r   <= 1'b0;
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            state_r  <= ST_RUN;
            busy_r   <= 1'b1;
            cnt_r    <= {CNT_W{1'b0}};
            op_r     <= op;
            neg_q_r  <= sign_a_s ^ sign_b_s;
            neg_r_r  <= sign_a_s;
            div0_r   <= op[1] && (src_b == {WIDTH{1'b0}});
            acc_r    <= op[1] ? {{WIDTH{1'b0}}, mag_a_s} : {(2*WIDTH){1'b0}};
            mcand_r  <= op[1] ? {{WIDTH{1'b0}}, mag_b_s} : {{WIDTH{1'b0}}, mag_a_s};
            mplier_r <= mag_b_s;
          end else begin
            state_r <= ST_IDLE;
            if (hi_we) hi_r <= wr_data;
            if (lo_we) lo_r <= wr_data;
          end
        end
        ST_RUN: begin
          acc_r    <= acc_nxt_s;
          mcand_r  <= op_r[1] ? mcand_r : (mcand_r << 1);
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + CNT_W'(1);
          if (last_s) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            hi_r    <= res_hi_s;
            lo_r    <= div0_r ? MDU_DIV0_LO[WIDTH-1:0] : res_lo_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: arithmetic reference model plus directed literal cases.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wr_data = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic        m_busy, m_done;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  int          m_rem;

  mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // {HI, LO} straight from the architectural definition of each operation.
  function automatic logic [63:0] model_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    case (o)
      2'b00: return sa * sb;
      2'b01: return {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Cycles from the accepting edge to the cycle where done is visible.
  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
    logic [31:0] m;
    int k;
    bit early;
    early = 1'b0;
`ifdef MDU_EARLY_TERM_EN
    early = 1'b1;
`endif
    m = (o == 2'b00 && b[31]) ? -b : b;
    k = 1;
    for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
    return (early && !o[1]) ? k + 1 : 33;
  endfunction

  // Reference model: countdown to completion, registers updated per architectural rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_hi <= 32'd0; m_lo <= 32'd0;
      m_rem <= 0; m_pend <= 64'd0;
    end else begin
      m_done <= 1'b0;
      if (m_rem != 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1;
          m_hi <= m_pend[63:32]; m_lo <= m_pend[31:0];
        end
      end else if (start) begin
        m_pend <= model_res(op, src_a, src_b);
        m_rem  <= exp_lat(op, src_b) - 1;
        m_busy <= 1'b1;
      end else begin
        if (hi_we) m_hi <= wr_data;
        if (lo_we) m_lo <= wr_data;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit imm, input bit interfere, input bit wr_with_start,
                        output int lat, output int bcnt);
    int n;
    if (!imm) @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    hi_we = wr_with_start; lo_we = wr_with_start; wr_data = $urandom;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    src_a = $urandom; src_b = $urandom; op = 2'($urandom_range(0, 3));
    n = 1; bcnt = 0;
    while (!done && n < 40) begin
      if (busy) bcnt++;
      if (interfere && n == 10) begin
        start = 1'b1; op = 2'b00; src_a = 32'd2; src_b = 32'd2; hi_we = 1'b1; wr_data = 32'h0000_AAAA;
      end else begin
        start = 1'b0; hi_we = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0; hi_we = 1'b0;
    lat = n;
    chk("latency", lat, exp_lat(o, b));
    chk("busy_cycles", bcnt, exp_lat(o, b) - 1);
  endtask

  task automatic wr_regs(input bit h, input bit l, input logic [31:0] d);
    @(negedge clk);
    hi_we = h; lo_we = l; wr_data = d;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
  endtask

  initial begin
    int lat, bc, dcnt;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, lat, bc);
    chk("multu_lat", lat, 32'd33);
    chk("multu_busy", bc, 32'd32);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd0);

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, 1'b0, lat, bc);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);

    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0, lat, bc);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_lo", lo, 32'hFFFF_FFFD);

    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, lat, bc);
    chk("divovf_hi", hi, 32'h0000_0000);
    chk("divovf_lo", lo, 32'h8000_0000);

    run_op(2'b11, 32'd100, 32'd0, 1'b0, 1'b0, 1'b0, lat, bc);
    chk("div0_lat", lat, 32'd33);
    chk("div0_hi", hi, 32'h0000_0064);
    chk("div0_lo", lo, 32'hFFFF_FFFF);

    run_op(2'b11, 32'd50, 32'd7, 1'b0, 1'b1, 1'b0, lat, bc);
    chk("interf_hi", hi, 32'h0000_0001);
    chk("interf_lo", lo, 32'h0000_0007);

    wr_regs(1'b1, 1'b0, 32'h1234_5678);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_lo", lo, 32'h0000_0007);
    wr_regs(1'b0, 1'b1, 32'h9ABC_DEF0);
    chk("mtlo_lo", lo, 32'h9ABC_DEF0);
    wr_regs(1'b1, 1'b1, 32'h0BAD_F00D);
    chk("mtboth_hi", hi, 32'h0BAD_F00D);
    chk("mtboth_lo", lo, 32'h0BAD_F00D);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = $urandom_range(0, 15);
        default: rb = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: ra = 32'h8000_0000;
        1: ra = $urandom_range(0, 100);
        default: ra = $urandom;
      endcase
      run_op(ro, ra, rb, $urandom_range(0, 2) == 0, 1'b0, $urandom_range(0, 3) == 0, lat, bc);
      if ($urandom_range(0, 3) == 0)
        wr_regs($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
    end

    @(negedge clk);
    start = 1'b1; op = 2'b11; src_a = 32'd1000; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("no_done_after_reset", dcnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
